// File: rtl/vga_mix_pkg.sv
// Shared constants and types for the VGA layer mixer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vga_mix_pkg;

    // hit_layer code for "background or blanked" pixels
    localparam logic [3:0] HIT_NONE = 4'hF;

    // Width of the blink frame counter; BLINK_FRAMES must fit below 2**BLINK_CNT_W
    localparam int BLINK_CNT_W = 8;

    localparam int DEFAULT_RGB_W        = 3;
    localparam int DEFAULT_N_LAYERS     = 4;
    localparam int DEFAULT_BLINK_FRAMES = 30;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_state_t;

endpackage

// File: rtl/vga_blink_timer.sv
// Frame-synchronous blink phase generator: toggles every BLINK_FRAMES frame_ticks.
// Latency: blink_phase changes on the clk edge that samples the wrapping frame_tick.
// Backpressure: none; frame_tick is a free-running pulse and is never stalled.
//
// Ports:
//   clk, reset (sync, active-high), frame_tick (1-cycle pulse per frame)
//   blink_phase: 0 = PHASE_ON (blinking layers visible), 1 = PHASE_OFF
module vga_blink_timer
    import vga_mix_pkg::*;
#(
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    output logic blink_phase
);

    localparam logic [BLINK_CNT_W-1:0] CNT_LAST = BLINK_CNT_W'(BLINK_FRAMES - 1);

    blink_state_t           state;
    blink_state_t           state_nxt;
    logic [BLINK_CNT_W-1:0] frame_cnt;
    logic [BLINK_CNT_W-1:0] frame_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PHASE_ON;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    // Counter wraps exactly at BLINK_FRAMES-1, so it never runs past the last value.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        if (frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt_nxt = '0;
                state_nxt     = (state == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frame_cnt_nxt = frame_cnt + 1'b1;
            end
        end
    end

    assign blink_phase = (state == PHASE_OFF);

endmodule

// File: rtl/vga_layer_mixer.sv
// Priority pixel mixer: picks the highest-priority visible layer, else bg_rgb, black when blanked.
// Latency: one pixel_tick; rgb/hit_layer load on pixel_tick edges and hold in between.
// Backpressure: none; pixel stream is paced by pixel_tick only.
//
// Ports:
//   clk, reset (sync, active-high), pixel_tick, frame_tick, video_on
//   layer_on/blink_mask/invert_mask [N_LAYERS], layer_rgb [N_LAYERS*RGB_W] (layer i at i*RGB_W),
//   bg_rgb [RGB_W]; outputs rgb [RGB_W], hit_layer [4] (HIT_NONE = background or blank)
// Optional: define VGA_MIX_INVERT_EN to let a winning layer with invert_mask set show the
//   inverted colour of whatever lies beneath it (cursor effect).
module vga_layer_mixer
    import vga_mix_pkg::*;
#(
    parameter int RGB_W        = DEFAULT_RGB_W,
    parameter int N_LAYERS     = DEFAULT_N_LAYERS,
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pixel_tick,
    input  logic                      frame_tick,
    input  logic                      video_on,
    input  logic [N_LAYERS-1:0]       layer_on,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       blink_mask,
    input  logic [RGB_W-1:0]          bg_rgb,
    input  logic [N_LAYERS-1:0]       invert_mask,
    output logic [RGB_W-1:0]          rgb,
    output logic [3:0]                hit_layer
);

    logic                blink_phase;
    logic [N_LAYERS-1:0] vis;
    logic                win_found;
    logic [3:0]          win_idx;
    logic [RGB_W-1:0]    win_rgb;
    logic [RGB_W-1:0]    below_rgb;
    logic                win_inv;
    logic [RGB_W-1:0]    sel_rgb;
    logic [3:0]          sel_hit;

    vga_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );

    assign vis = layer_on & ~(blink_mask & {N_LAYERS{blink_phase}});

    // Scan from lowest to highest priority. Each visible layer pushes the previous
    // candidate down into below_rgb, so at the end win_rgb is the winner and
    // below_rgb is the next lower-priority visible colour (or bg_rgb if none).
    always_comb begin
        win_found = 1'b0;
        win_idx   = HIT_NONE;
        win_rgb   = bg_rgb;
        below_rgb = bg_rgb;
        win_inv   = 1'b0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (vis[i]) begin
                below_rgb = win_rgb;
                win_found = 1'b1;
                win_idx   = 4'(i);
                win_rgb   = layer_rgb[i*RGB_W +: RGB_W];
`ifdef VGA_MIX_INVERT_EN
                win_inv   = invert_mask[i];
`endif
            end
        end
    end

`ifndef VGA_MIX_INVERT_EN
    // invert_mask has no function in this build
    logic unused_invert_mask;
    assign unused_invert_mask = ^invert_mask;
`endif

    // Blanking outranks everything, including the inverted-cursor path.
    always_comb begin
        sel_rgb = '0;
        sel_hit = HIT_NONE;
        if (video_on) begin
            if (win_found) begin
                sel_rgb = win_inv ? ~below_rgb : win_rgb;
                sel_hit = win_idx;
            end else begin
                sel_rgb = bg_rgb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb       <= '0;
            hit_layer <= HIT_NONE;
        end else if (pixel_tick) begin
            rgb       <= sel_rgb;
            hit_layer <= sel_hit;
        end
    end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer (RGB_W=3, N_LAYERS=4, BLINK_FRAMES=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_layer_mixer;
    import vga_mix_pkg::*;

    localparam int RW = 3;
    localparam int NL = 4;
    localparam int BF = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            pixel_tick = 1'b0;
    logic            frame_tick = 1'b0;
    logic            video_on = 1'b0;
    logic [NL-1:0]   layer_on = '0;
    logic [NL*RW-1:0] layer_rgb = '0;
    logic [NL-1:0]   blink_mask = '0;
    logic [RW-1:0]   bg_rgb = '0;
    logic [NL-1:0]   invert_mask = '0;
    logic [RW-1:0]   rgb;
    logic [3:0]      hit_layer;

    vga_layer_mixer #(
        .RGB_W        (RW),
        .N_LAYERS     (NL),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_tick  (pixel_tick),
        .frame_tick  (frame_tick),
        .video_on    (video_on),
        .layer_on    (layer_on),
        .layer_rgb   (layer_rgb),
        .blink_mask  (blink_mask),
        .bg_rgb      (bg_rgb),
        .invert_mask (invert_mask),
        .rgb         (rgb),
        .hit_layer   (hit_layer)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // expected {hit_layer, rgb}
    logic [6:0] exp_q[$];
    logic [6:0] cur_exp;
    int         m_cnt   = 0;
    logic       m_phase = 1'b0;

    // Reference pixel model: independent of the RGB loop structure.
    function automatic logic [6:0] model(input logic ph);
        logic [NL-1:0] v;
        int            w;
        logic [RW-1:0] c;
        v = layer_on & ~(blink_mask & {NL{ph}});
        if (!video_on) return {HIT_NONE, 3'b000};
        w = -1;
        for (int i = 0; i < NL; i++)
            if (v[i] && w < 0) w = i;
        if (w < 0) return {HIT_NONE, bg_rgb};
        c = layer_rgb[w*RW +: RW];
`ifdef VGA_MIX_INVERT_EN
        if (invert_mask[w]) begin
            int nx;
            nx = -1;
            for (int j = w + 1; j < NL; j++)
                if (v[j] && nx < 0) nx = j;
            c = (nx < 0) ? ~bg_rgb : ~layer_rgb[nx*RW +: RW];
        end
`endif
        return {4'(w), c};
    endfunction

    // One clock: drive at negedge, update model, sample #1 after posedge, check scoreboard.
    task automatic step(input logic pt, input logic ft, input logic rst, input string tag);
        @(negedge clk);
        pixel_tick = pt;
        frame_tick = ft;
        reset      = rst;
        if (rst) begin
            exp_q.push_back({HIT_NONE, 3'b000});
            m_cnt   = 0;
            m_phase = 1'b0;
        end else begin
            if (pt) exp_q.push_back(model(m_phase));
            if (ft) begin
                if (m_cnt == BF - 1) begin
                    m_cnt   = 0;
                    m_phase = ~m_phase;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
        n_assert++;
        assert (rgb === cur_exp[2:0]) else begin
            n_fail++;
            $error("FAIL %s rgb observed=%b expected=%b", tag, rgb, cur_exp[2:0]);
        end
        n_assert++;
        assert (hit_layer === cur_exp[6:3]) else begin
            n_fail++;
            $error("FAIL %s hit_layer observed=%h expected=%h", tag, hit_layer, cur_exp[6:3]);
        end
    endtask

    // Directed check against a hand-derived constant.
    task automatic chk(input string tag, input logic [RW-1:0] exp_rgb, input logic [3:0] exp_hit);
        n_assert++;
        assert (rgb === exp_rgb) else begin
            n_fail++;
            $error("FAIL %s rgb observed=%b expected=%b", tag, rgb, exp_rgb);
        end
        n_assert++;
        assert (hit_layer === exp_hit) else begin
            n_fail++;
            $error("FAIL %s hit_layer observed=%h expected=%h", tag, hit_layer, exp_hit);
        end
    endtask

    task automatic chk_phase(input string tag, input logic exp_ph);
        n_assert++;
        assert (dut.u_blink.blink_phase === exp_ph) else begin
            n_fail++;
            $error("FAIL %s blink_phase observed=%b expected=%b", tag, dut.u_blink.blink_phase, exp_ph);
        end
    endtask

    initial begin
        // 1. reset for 3 cycles with pixel_tick high; layers active to prove reset wins
        video_on  = 1'b1;
        layer_on  = 4'b1111;
        layer_rgb = 12'b111_111_111_111;
        step(1, 1, 1, "reset0");
        step(1, 1, 1, "reset1");
        step(1, 0, 1, "reset2");
        chk("reset_state", 3'b000, HIT_NONE);
        chk_phase("reset_phase", 1'b0);

        // 2. priority: L1 beats L2; then background
        layer_on  = 4'b0110;
        layer_rgb = 12'b000_100_010_000;
        bg_rgb    = 3'b000;
        step(1, 0, 0, "prio");
        chk("prio_l1", 3'b010, 4'h1);
        layer_on = 4'b0000;
        bg_rgb   = 3'b001;
        step(1, 0, 0, "bg");
        chk("bg_fallback", 3'b001, HIT_NONE);

        // 3. blanking overrides all layers
        video_on = 1'b0;
        layer_on = 4'b1111;
        step(1, 0, 0, "blank");
        chk("blank", 3'b000, HIT_NONE);

        // hold between sparse pixel_ticks (every 4th clk)
        video_on = 1'b1;
        layer_on = 4'b0100;
        step(1, 0, 0, "hold_load");
        chk("hold_load", 3'b100, 4'h2);
        layer_on = 4'b0010;
        step(0, 0, 0, "hold1");
        step(0, 0, 0, "hold2");
        step(0, 0, 0, "hold3");
        chk("hold_kept", 3'b100, 4'h2);
        step(1, 0, 0, "hold_next");
        chk("hold_next", 3'b010, 4'h1);

        // 4. blink with BLINK_FRAMES = 2
        layer_on   = 4'b0001;
        layer_rgb  = 12'b000_000_000_111;
        blink_mask = 4'b0001;
        bg_rgb     = 3'b000;
        step(1, 0, 0, "blink_on0");
        chk("blink_on0", 3'b111, 4'h0);
        step(0, 1, 0, "ft1");
        step(0, 1, 0, "ft2");
        step(1, 0, 0, "blink_off");
        chk("blink_off_after2", 3'b000, HIT_NONE);
        step(0, 1, 0, "ft3");
        step(1, 1, 0, "coincident");
        chk("coincident_old_phase", 3'b000, HIT_NONE);
        step(1, 0, 0, "blink_on1");
        chk("blink_on_after4", 3'b111, 4'h0);

        // 5. reset mid-blink while in PHASE_OFF
        step(0, 1, 0, "ft5");
        step(0, 1, 0, "ft6");
        step(0, 1, 0, "ft7");
        step(1, 0, 0, "pre_reset");
        chk("pre_reset_off", 3'b000, HIT_NONE);
        step(1, 0, 1, "mid_reset");
        chk("mid_reset_black", 3'b000, HIT_NONE);
        chk_phase("mid_reset_phase", 1'b0);
        step(1, 0, 0, "post_reset");
        chk("post_reset_on", 3'b111, 4'h0);
        step(0, 1, 0, "ft_after_reset");
        step(1, 0, 0, "no_toggle");
        chk("one_ft_no_toggle", 3'b111, 4'h0);
        step(0, 1, 0, "ft_second");
        step(1, 0, 0, "toggle");
        chk("second_ft_toggles", 3'b000, HIT_NONE);

        // 6. invert cursor
        step(0, 1, 0, "ft_back_on");
        blink_mask  = 4'b0000;
        layer_on    = 4'b0011;
        invert_mask = 4'b0001;
        layer_rgb   = 12'b000_000_010_110;
        step(1, 0, 0, "invert");
`ifdef VGA_MIX_INVERT_EN
        chk("invert_on", 3'b101, 4'h0);
`else
        chk("invert_off", 3'b110, 4'h0);
`endif

        // randomized traffic, checked by the scoreboard model
        for (int k = 0; k < 300; k++) begin
            video_on    = ($urandom_range(0, 3) != 0);
            layer_on    = NL'($urandom);
            layer_rgb   = (NL*RW)'($urandom);
            blink_mask  = NL'($urandom);
            bg_rgb      = RW'($urandom);
            invert_mask = NL'($urandom);
            step(logic'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 49) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
